ehl_fifo_rc: RTL and testbench
==============================

EHL_FIFO_RC -- requirements
Module: ehl_fifo_rc

Interface
REQ-001 SHALL have parameter FIFO_ADR_WIDTH, default 5: row address width, equal to log2(FIFO_DEPTH).
REQ-002 SHALL have parameter FIFO_CNT, default 1: number of parallel storage lanes (power of 2).
REQ-003 SHALL have parameter WC_CNT, default 1: number of lanes written per write.
REQ-004 SHALL have parameter RC_CNT, default 1: number of lanes read per read (1 or FIFO_CNT).
REQ-005 SHALL have parameter FIFO_DEPTH, default 32: rows per lane (power of 2).
REQ-006 SHALL have port rclk, input, 1 bit: read clock; this is the only clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port rd, input, 1 bit: read request.
REQ-009 SHALL have port clr_uf, input, 1 bit: clears the sticky underflow flag.
REQ-010 SHALL have port wptr_gray, input, FIFO_ADR_WIDTH+1 bits: write row pointer (Gray), already synchronized to rclk.
REQ-011 SHALL have port rptr_gray, output, FIFO_ADR_WIDTH+1 bits: registered read row pointer (Gray).
REQ-012 SHALL have port raddr, output, FIFO_ADR_WIDTH bits (1 bit when FIFO_DEPTH==1): RAM read row address.
REQ-013 SHALL have port rsel, output, FIFO_CNT bits: lane select of the current accepted read.
REQ-014 SHALL have port r_valid, output, 1 bit: RAM read data valid, one cycle after an accepted read.
REQ-015 SHALL have ports r_empty, r_aempty, r_afull, r_full, outputs, 1 bit each: fill-level flags.
REQ-016 SHALL have port r_underflow, output, 1 bit: sticky read-while-empty flag.
REQ-017 SHALL have port read_credit, output, clog2(FIFO_CNT*FIFO_DEPTH)+1 bits: number of entries available to read.

Function
REQ-018 SHALL keep an entry-granular binary read address raddr_bin of clog2(FIFO_CNT*FIFO_DEPTH)+1 bits that wraps modulo 2*FIFO_CNT*FIFO_DEPTH.
REQ-019 SHALL define INCR = 1 when RC_CNT==1 and FIFO_CNT>1, and INCR = FIFO_CNT otherwise.
REQ-020 SHALL define an accepted read as acc = rd & !r_empty, and SHALL advance raddr_bin by INCR on each acc.
REQ-021 SHALL drive lane pointer lptr = 1<<raddr_bin[log2(FIFO_CNT)-1:0] when INCR==1, and all ones otherwise; lptr SHALL be 1'b1 when FIFO_CNT==1.
REQ-022 SHALL drive rsel = lptr when acc is high, and 0 otherwise (combinational).
REQ-023 SHALL advance the Gray read row counter by one on acc & lptr[FIFO_CNT-1], and SHALL output it registered on rptr_gray, wrapping at 2*FIFO_DEPTH.
REQ-024 SHALL drive raddr = raddr_bin[log2(FIFO_CNT) +: FIFO_ADR_WIDTH], tied to 0 when FIFO_DEPTH==1.
REQ-025 SHALL convert wptr_gray to binary wptr_bin combinationally.
REQ-026 SHALL compute read_credit = (wptr_bin << log2(FIFO_CNT)) - raddr_bin, modulo the read_credit width; the result never exceeds FIFO_CNT*FIFO_DEPTH.
REQ-027 SHALL assert r_empty when read_credit < INCR.
REQ-028 SHALL assert r_aempty when read_credit == INCR.
REQ-029 SHALL assert r_afull when read_credit == FIFO_CNT*FIFO_DEPTH - INCR.
REQ-030 SHALL assert r_full when read_credit == FIFO_CNT*FIFO_DEPTH.
REQ-031 SHALL register r_valid as acc delayed by one rclk.
REQ-032 SHALL ignore rd while r_empty is high: no pointer change and r_valid stays 0 next cycle.
REQ-033 SHALL set r_underflow on rd & r_empty, and SHALL clear it on clr_uf; clr_uf has priority over set when both occur in the same cycle.
REQ-034 SHALL, in non-synthesis builds, print an error message with the time whenever underflow is set.
REQ-035 SHALL let a wptr_gray change and an accepted read in the same cycle both take effect; the credit uses the new values on the next cycle.
REQ-036 SHALL wrap pointers silently; full and empty SHALL be distinguished by the pointer MSB via the credit arithmetic.

Reset
REQ-037 SHALL, while reset is high and independent of rclk, clear raddr_bin, the Gray counter, rptr_gray, r_valid and r_underflow to 0.
REQ-038 SHALL, during reset with wptr_gray==0, show r_empty=1, r_full=0, rsel=0 and read_credit=0.
REQ-039 SHALL, on reset asserted mid-burst, drop r_valid on the same edge as reset and discard pending reads.

Verification
REQ-040 SHALL cover FIFO_DEPTH=4, FIFO_CNT=1: wptr_gray steps 0->1->3 -> read_credit 1 then 2; two rd pulses -> raddr 0,1, r_valid one cycle after each read, r_empty=1 after the second read.
REQ-041 SHALL cover FIFO_DEPTH=4, FIFO_CNT=1 full and wrap: wptr_bin=4 -> r_full=1, read_credit=4; 4 reads -> rptr_gray=3'b110; writes to wptr_bin=7, then 3 reads -> raddr 0,1,2 with no false flags.
REQ-042 SHALL cover underflow: rd while empty -> r_underflow=1 and no pointer change; clr_uf and rd together while empty -> r_underflow=0.
REQ-043 SHALL cover FIFO_CNT=4, RC_CNT=1, FIFO_DEPTH=2: wptr_bin=1 -> 4 reads -> rsel 0001, 0010, 0100, 1000, and rptr_gray increments only on the fourth read.
REQ-044 SHALL cover FIFO_CNT=4, RC_CNT=4: each read -> rsel=1111, raddr_bin +4, r_aempty when read_credit==4.
REQ-045 SHALL cover asynchronous reset pulsed between clock edges during a read burst -> all registers 0 immediately and r_empty=1 with wptr_gray=0.

Source files
------------

// File: rtl/ehl_fifo_rc.sv
// Read-side control of a multi-lane async FIFO: read pointers, fill-level flags and read credit.
// All logic runs on rclk; wptr_gray arrives already synchronized into this domain.
module ehl_fifo_rc #(
  parameter int FIFO_ADR_WIDTH = 5,
  parameter int FIFO_CNT       = 1,
  parameter int WC_CNT         = 1,
  parameter int RC_CNT         = 1,
  parameter int FIFO_DEPTH     = 32,
  localparam int RA_W = (FIFO_DEPTH == 1) ? 1 : FIFO_ADR_WIDTH,
  localparam int CR_W = $clog2(FIFO_CNT * FIFO_DEPTH) + 1,
  localparam int RW   = FIFO_ADR_WIDTH + 1
) (
  input  logic                rclk,
  input  logic                reset,
  input  logic                rd,
  input  logic                clr_uf,
  input  logic [RW-1:0]       wptr_gray,
  output logic [RW-1:0]       rptr_gray,
  output logic [RA_W-1:0]     raddr,
  output logic [FIFO_CNT-1:0] rsel,
  output logic                r_valid,
  output logic                r_empty,
  output logic                r_aempty,
  output logic                r_afull,
  output logic                r_full,
  output logic                r_underflow,
  output logic [CR_W-1:0]     read_credit
);

  localparam int LW   = $clog2(FIFO_CNT);
  localparam int INCR = (RC_CNT == 1 && FIFO_CNT > 1) ? 1 : FIFO_CNT;
  localparam logic [CR_W-1:0] INCR_C  = CR_W'(INCR);
  localparam logic [CR_W-1:0] TOTAL_C = CR_W'(FIFO_CNT * FIFO_DEPTH);

  logic [CR_W-1:0]     r_raddr_bin;
  logic [RW-1:0]       r_rptr_gray;
  logic [CR_W-1:0]     w_raddr_nxt;
  logic [RW-1:0]       w_row_nxt;
  logic [RW-1:0]       w_wptr_bin;
  logic [CR_W-1:0]     w_credit;
  logic [FIFO_CNT-1:0] w_lptr;
  logic                w_empty;
  logic                w_acc;

  always_comb begin
    w_wptr_bin = '0;
    for (int i = 0; i < RW; i++) begin
      w_wptr_bin[i] = ^(wptr_gray >> i);
    end
  end

  // Rows are scaled to entries so both pointers share one modulo-2N space; MSB separates full/empty.
  assign w_credit    = (CR_W'(w_wptr_bin) << LW) - r_raddr_bin;
  assign w_empty     = w_credit < INCR_C;
  assign w_acc       = rd & ~w_empty;
  assign w_raddr_nxt = r_raddr_bin + INCR_C;
  assign w_row_nxt   = RW'(w_raddr_nxt >> LW);

  if (FIFO_CNT == 1) begin : g_lptr_one
    assign w_lptr = 1'b1;
  end else if (INCR == 1) begin : g_lptr_walk
    assign w_lptr = {{(FIFO_CNT-1){1'b0}}, 1'b1} << r_raddr_bin[LW-1:0];
  end else begin : g_lptr_all
    assign w_lptr = '1;
  end

  if (FIFO_DEPTH == 1) begin : g_raddr_zero
    assign raddr = 1'b0;
  end else begin : g_raddr_row
    assign raddr = r_raddr_bin[LW +: FIFO_ADR_WIDTH];
  end

  assign rsel        = w_acc ? w_lptr : '0;
  assign rptr_gray   = r_rptr_gray;
  assign read_credit = w_credit;
  assign r_empty     = w_empty;
  assign r_aempty    = w_credit == INCR_C;
  assign r_afull     = w_credit == TOTAL_C - INCR_C;
  assign r_full      = w_credit == TOTAL_C;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_raddr_bin <= '0;
      r_rptr_gray <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_raddr_bin <= w_raddr_nxt;
      end
      // Row pointer moves only once the last lane of the row has been consumed.
      if (w_acc && w_lptr[FIFO_CNT-1]) begin
        r_rptr_gray <= w_row_nxt ^ (w_row_nxt >> 1);
      end
      if (clr_uf) begin
        r_underflow <= 1'b0;
      end else if (rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge rclk) begin
    if (!reset && rd && w_empty && !clr_uf) begin
      $display("ehl_fifo_rc (w%0d/r%0d lanes): underflow, read while empty at %0t",
               WC_CNT, RC_CNT, $time);
    end
  end
`endif

endmodule

// File: tb/tb_ehl_fifo_rc.sv
// Self-checking bench for ehl_fifo_rc: three configurations, a vector table, corner sequences
// and randomized traffic against an entry-counting reference model.
module tb_ehl_fifo_rc;

  logic clk;
  logic reset;
  logic rd_i  [3];
  logic clr_i [3];
  logic [2:0] wg0;
  logic [1:0] wg1, wg2;

  logic [2:0] cr0, rp0;  logic [1:0] ra0;  logic       rs0;
  logic [3:0] cr1, rs1;  logic [1:0] rp1;  logic       ra1;
  logic [3:0] cr2, rs2;  logic [1:0] rp2;  logic       ra2;
  logic v0, e0, ae0, af0, f0, u0;
  logic v1, e1, ae1, af1, f1, u1;
  logic v2, e2, ae2, af2, f2, u2;

  typedef struct packed {
    logic [3:0] credit;
    logic [2:0] rptr;
    logic [1:0] raddr;
    logic [3:0] rsel;
    logic valid, empty, aempty, afull, full, uf;
  } obs_t;

  typedef struct {
    bit rst; int w; bit rd; bit clr;
    int credit; bit empty, aempty, afull, full;
    int raddr; bit valid, uf; int rptr;
  } vec_t;

  obs_t obs [3];
  vec_t tbl [$];

  int CC [3] = '{1, 4, 4};
  int DD [3] = '{4, 2, 2};
  int II [3] = '{1, 1, 4};
  int m_rows [3], m_reads [3];
  bit m_valid [3], m_uf [3];
  int tests = 0;
  int fails = 0;

  ehl_fifo_rc #(.FIFO_ADR_WIDTH(2), .FIFO_CNT(1), .WC_CNT(1), .RC_CNT(1), .FIFO_DEPTH(4)) u_d4 (
    .rclk(clk), .reset(reset), .rd(rd_i[0]), .clr_uf(clr_i[0]), .wptr_gray(wg0),
    .rptr_gray(rp0), .raddr(ra0), .rsel(rs0), .r_valid(v0), .r_empty(e0), .r_aempty(ae0),
    .r_afull(af0), .r_full(f0), .r_underflow(u0), .read_credit(cr0));

  ehl_fifo_rc #(.FIFO_ADR_WIDTH(1), .FIFO_CNT(4), .WC_CNT(1), .RC_CNT(1), .FIFO_DEPTH(2)) u_q4 (
    .rclk(clk), .reset(reset), .rd(rd_i[1]), .clr_uf(clr_i[1]), .wptr_gray(wg1),
    .rptr_gray(rp1), .raddr(ra1), .rsel(rs1), .r_valid(v1), .r_empty(e1), .r_aempty(ae1),
    .r_afull(af1), .r_full(f1), .r_underflow(u1), .read_credit(cr1));

  ehl_fifo_rc #(.FIFO_ADR_WIDTH(1), .FIFO_CNT(4), .WC_CNT(4), .RC_CNT(4), .FIFO_DEPTH(2)) u_w4 (
    .rclk(clk), .reset(reset), .rd(rd_i[2]), .clr_uf(clr_i[2]), .wptr_gray(wg2),
    .rptr_gray(rp2), .raddr(ra2), .rsel(rs2), .r_valid(v2), .r_empty(e2), .r_aempty(ae2),
    .r_afull(af2), .r_full(f2), .r_underflow(u2), .read_credit(cr2));

  assign obs[0] = {1'b0, cr0, rp0, ra0, 3'b000, rs0, v0, e0, ae0, af0, f0, u0};
  assign obs[1] = {cr1, 1'b0, rp1, 1'b0, ra1, rs1, v1, e1, ae1, af1, f1, u1};
  assign obs[2] = {cr2, 1'b0, rp2, 1'b0, ra2, rs2, v2, e2, ae2, af2, f2, u2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray(int v);
    return v ^ (v >> 1);
  endfunction

  // Reference: writer has produced m_rows whole rows, reader has taken m_reads entries.
  function automatic obs_t exp_obs(int k);
    obs_t e;
    int cr, row, lanes;
    cr  = m_rows[k] * CC[k] - m_reads[k];
    row = m_reads[k] / CC[k];
    if (CC[k] == 1)      lanes = 1;
    else if (II[k] == 1) lanes = 1 << (m_reads[k] % CC[k]);
    else                 lanes = 15;
    e.credit = 4'(cr);
    e.rptr   = 3'(gray(row % (2 * DD[k])));
    e.raddr  = 2'(row % DD[k]);
    e.empty  = cr < II[k];
    e.aempty = cr == II[k];
    e.afull  = cr == CC[k] * DD[k] - II[k];
    e.full   = cr == CC[k] * DD[k];
    e.rsel   = (rd_i[k] && !e.empty) ? 4'(lanes) : 4'd0;
    e.valid  = m_valid[k];
    e.uf     = m_uf[k];
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_model(input int k);
    cmp($sformatf("model_dut%0d", k), 32'(obs[k]), 32'(exp_obs(k)));
  endtask

  task automatic set_rows(input int k, input int n);
    int g;
    m_rows[k] = n;
    g = gray(n % (2 * DD[k]));
    case (k)
      0:       wg0 = 3'(g);
      1:       wg1 = 2'(g);
      default: wg2 = 2'(g);
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      set_rows(k, 0);
      m_reads[k] = 0;
      m_valid[k] = 1'b0;
      m_uf[k]    = 1'b0;
    end
  endtask

  task automatic tick();
    bit emp, acc;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      emp = (m_rows[k] * CC[k] - m_reads[k]) < II[k];
      acc = rd_i[k] && !emp;
      if (reset) begin
        m_valid[k] = 1'b0;
      end else begin
        m_valid[k] = acc;
        if (acc) m_reads[k] += II[k];
        if (clr_i[k]) m_uf[k] = 1'b0;
        else if (rd_i[k] && emp) m_uf[k] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_i[k] = 1'b0;
      clr_i[k] = 1'b0;
    end
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) check_model(k);
    tick();
    reset = 1'b0;
  endtask

  task automatic add(input bit rst, input int w, input bit rd, input bit clr, input int credit,
                     input bit em, input bit ae, input bit af, input bit fu, input int raddr,
                     input bit va, input bit uf, input int rptr);
    vec_t v;
    v.rst = rst; v.w = w; v.rd = rd; v.clr = clr; v.credit = credit;
    v.empty = em; v.aempty = ae; v.afull = af; v.full = fu;
    v.raddr = raddr; v.valid = va; v.uf = uf; v.rptr = rptr;
    tbl.push_back(v);
  endtask

  initial begin
    obs_t e;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_i[k] = 1'b0;
      clr_i[k] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("rst_empty%0d", k), 32'(obs[k].empty), 1);
      cmp($sformatf("rst_full%0d", k), 32'(obs[k].full), 0);
      cmp($sformatf("rst_rsel%0d", k), 32'(obs[k].rsel), 0);
      cmp($sformatf("rst_credit%0d", k), 32'(obs[k].credit), 0);
    end
    tick();
    reset = 1'b0;

    //  rst w rd clr  cred em ae af fu  raddr va uf rptr   (FIFO_DEPTH=4, FIFO_CNT=1)
    add(1, 0, 0, 0,   0,  1, 0, 0, 0,   0,    0, 0, 0);
    add(0, 1, 0, 0,   1,  0, 1, 0, 0,   0,    0, 0, 0);
    add(0, 2, 0, 0,   2,  0, 0, 0, 0,   0,    0, 0, 0);
    add(0, 2, 1, 0,   2,  0, 0, 0, 0,   0,    0, 0, 0);
    add(0, 2, 1, 0,   1,  0, 1, 0, 0,   1,    1, 0, 1);
    add(0, 2, 0, 0,   0,  1, 0, 0, 0,   2,    1, 0, 3);
    add(0, 2, 0, 0,   0,  1, 0, 0, 0,   2,    0, 0, 3);
    add(0, 2, 1, 0,   0,  1, 0, 0, 0,   2,    0, 0, 3);
    add(0, 2, 0, 0,   0,  1, 0, 0, 0,   2,    0, 1, 3);
    add(0, 2, 1, 1,   0,  1, 0, 0, 0,   2,    0, 1, 3);
    add(0, 2, 0, 0,   0,  1, 0, 0, 0,   2,    0, 0, 3);
    add(1, 0, 0, 0,   0,  1, 0, 0, 0,   0,    0, 0, 0);
    add(0, 4, 1, 0,   4,  0, 0, 0, 1,   0,    0, 0, 0);
    add(0, 4, 1, 0,   3,  0, 0, 1, 0,   1,    1, 0, 1);
    add(0, 4, 1, 0,   2,  0, 0, 0, 0,   2,    1, 0, 3);
    add(0, 4, 1, 0,   1,  0, 1, 0, 0,   3,    1, 0, 2);
    add(0, 4, 0, 0,   0,  1, 0, 0, 0,   0,    1, 0, 6);
    add(0, 7, 1, 0,   3,  0, 0, 1, 0,   0,    0, 0, 6);
    add(0, 7, 1, 0,   2,  0, 0, 0, 0,   1,    1, 0, 7);
    add(0, 7, 1, 0,   1,  0, 1, 0, 0,   2,    1, 0, 5);
    add(0, 7, 0, 0,   0,  1, 0, 0, 0,   3,    1, 0, 4);

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      if (tbl[i].rst) model_reset();
      set_rows(0, tbl[i].w);
      rd_i[0]  = tbl[i].rd;
      clr_i[0] = tbl[i].clr;
      #2;
      e.credit = 4'(tbl[i].credit);
      e.rptr   = 3'(tbl[i].rptr);
      e.raddr  = 2'(tbl[i].raddr);
      e.rsel   = {3'b000, tbl[i].rd & ~tbl[i].empty & ~tbl[i].rst};
      e.valid  = tbl[i].valid;
      e.empty  = tbl[i].empty;
      e.aempty = tbl[i].aempty;
      e.afull  = tbl[i].afull;
      e.full   = tbl[i].full;
      e.uf     = tbl[i].uf;
      cmp($sformatf("vec%0d", i), 32'(obs[0]), 32'(e));
      check_model(0);
      tick();
    end
    reset = 1'b0;
    rd_i[0] = 1'b0;
    clr_i[0] = 1'b0;

    // Four-lane walking read: one row feeds four single-lane reads.
    do_reset();
    set_rows(1, 1);
    rd_i[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      cmp($sformatf("q4_rsel%0d", i), 32'(obs[1].rsel), 32'(1 << i));
      cmp($sformatf("q4_rptr%0d", i), 32'(obs[1].rptr), 0);
      check_model(1);
      tick();
    end
    #2;
    cmp("q4_rsel_empty", 32'(obs[1].rsel), 0);
    cmp("q4_rptr_adv", 32'(obs[1].rptr), 1);
    cmp("q4_empty", 32'(obs[1].empty), 1);
    rd_i[1] = 1'b0;
    tick();

    // Full-width reads: every lane at once.
    do_reset();
    set_rows(2, 2);
    rd_i[2] = 1'b1;
    #2;
    cmp("w4_rsel0", 32'(obs[2].rsel), 15);
    cmp("w4_full", 32'(obs[2].full), 1);
    cmp("w4_aempty0", 32'(obs[2].aempty), 0);
    tick();
    #2;
    cmp("w4_rsel1", 32'(obs[2].rsel), 15);
    cmp("w4_raddr1", 32'(obs[2].raddr), 1);
    cmp("w4_credit4", 32'(obs[2].credit), 4);
    cmp("w4_aempty1", 32'(obs[2].aempty), 1);
    tick();
    #2;
    cmp("w4_empty", 32'(obs[2].empty), 1);
    cmp("w4_rsel_none", 32'(obs[2].rsel), 0);
    cmp("w4_rptr", 32'(obs[2].rptr), 3);
    check_model(2);
    rd_i[2] = 1'b0;
    tick();

    // Randomized traffic on all three configurations.
    for (int n = 0; n < 1500; n++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(199) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      for (int k = 0; k < 3; k++) begin
        if (!reset && $urandom_range(1) == 1 &&
            m_rows[k] * CC[k] - m_reads[k] + CC[k] <= CC[k] * DD[k])
          set_rows(k, m_rows[k] + 1);
        rd_i[k]  = ($urandom_range(2) != 0);
        clr_i[k] = ($urandom_range(7) == 0);
      end
      #2;
      for (int k = 0; k < 3; k++) check_model(k);
      tick();
    end

    // Reset pulsed between edges in the middle of a read burst.
    reset = 1'b0;
    for (int k = 0; k < 3; k++) clr_i[k] = 1'b0;
    do_reset();
    set_rows(0, 3);
    rd_i[0] = 1'b1;
    #2;
    check_model(0);
    tick();
    #2;
    cmp("mid_valid_before", 32'(obs[0].valid), 1);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    cmp("mid_valid", 32'(obs[0].valid), 0);
    cmp("mid_raddr", 32'(obs[0].raddr), 0);
    cmp("mid_rptr", 32'(obs[0].rptr), 0);
    cmp("mid_empty", 32'(obs[0].empty), 1);
    cmp("mid_credit", 32'(obs[0].credit), 0);
    cmp("mid_rsel", 32'(obs[0].rsel), 0);
    tick();
    reset = 1'b0;
    rd_i[0] = 1'b0;
    #2;
    check_model(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
